// File: rtl/shift_reg_universal_pkg.sv
// Shared encodings for the universal shift register: register ops, FSM states
// and burst directions, plus the mapping from a burst direction to a shift op.
package shift_reg_universal_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    function automatic logic [1:0] burst_op(input logic dir);
        return (dir == DIR_LEFT) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/shift_reg_universal_shift_core.sv
// Storage register with hold / shift right / shift left / parallel load,
// built bit-by-bit so each bit only sees its neighbours and the serial inputs.
module shift_core
    import shift_reg_universal_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic             sdi_l,
    input  logic             sdi_r,
    input  logic [WIDTH-1:0] pdi,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic from_left;
            logic from_right;

            // End bits take the serial inputs instead of a neighbour.
            if (gi == WIDTH - 1) begin : g_top
                assign from_left = sdi_l;
            end else begin : g_mid_l
                assign from_left = q_reg[gi+1];
            end

            if (gi == 0) begin : g_bot
                assign from_right = sdi_r;
            end else begin : g_mid_r
                assign from_right = q_reg[gi-1];
            end

            assign q_next[gi] = (op == MODE_SHR)  ? from_left  :
                                (op == MODE_SHL)  ? from_right :
                                (op == MODE_LOAD) ? pdi[gi]    :
                                                    q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register with an autonomous burst engine: the FSM takes
// over the register op for burst_len back-to-back shifts, then pulses done.
module shift_reg_universal
    import shift_reg_universal_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             sdi_l,
    input  logic             sdi_r,
    input  logic [WIDTH-1:0] pdi,
    input  logic             start,
    input  logic             burst_dir,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] pdo,
    output logic             sdo_r,
    output logic             sdo_l,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [1:0]       core_op;
    logic [WIDTH-1:0] q;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        core_op    = mode;
        case (state_reg)
            ST_IDLE: begin
                // A start request claims the edge: the register holds while the burst is armed.
                if (start) begin
                    core_op = MODE_HOLD;
                    if (burst_len != '0) begin
                        state_next = ST_BURST;
                        cnt_next   = burst_len;
                        dir_next   = burst_dir;
                        busy_next  = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                core_op  = burst_op(dir_reg);
                cnt_next = cnt_reg - LEN_W'(1);
                if (cnt_reg == LEN_W'(1)) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dir_reg   <= DIR_RIGHT;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .op    (core_op),
        .sdi_l (sdi_l),
        .sdi_r (sdi_r),
        .pdi   (pdi),
        .q     (q)
    );

    assign pdo   = q;
    assign sdo_r = q[0];
    assign sdo_l = q[WIDTH-1];
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule
